cp0_intc: RTL and testbench
===========================

CP0_INTC -- requirements
Module: cp0_intc

Interface
REQ-001 SHALL provide parameter N_EXT, default 6, number of external interrupt lines (1..8).
REQ-002 SHALL provide parameter N_TIMER, default 1, number of compare channels (1..4).
REQ-003 SHALL provide parameter COUNT_DIV, default 2, clk cycles per count increment (1..16).
REQ-004 SHALL provide parameter EDGE_MASK, width N_EXT, default 0, where bit=1 makes that ext line edge-latched and bit=0 makes it level.
REQ-005 SHALL define P = 2+N_EXT+N_TIMER pending bits: [1:0] soft, [2+N_EXT-1:2] ext, top N_TIMER bits timer.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ext_int  in  N_EXT  raw external interrupt lines.
REQ-009 wr_en  in  1  software register write strobe.
REQ-010 wr_sel / rd_sel  in  4  register select: 0 count, 1 status, 2 cause, 3+i compare[i].
REQ-011 wr_data  in  32  write data.
REQ-012 rd_data  out  32  combinational read of rd_sel; unmapped selects read 0.
REQ-013 int_ack  in  1  pipeline commits the interrupt this cycle.
REQ-014 eret  in  1  exception return.
REQ-015 int_req  out  1  interrupt request.
REQ-016 int_pend  out  P  ip & im, exposed for cause decoding.

Function
REQ-017 SHALL hold status: bit0 IE, bit1 EXL, bits[16+P-1:16] IM; other status bits read 0.
REQ-018 SHALL present cause bits[P-1:0] as ip; writes affect only soft bits [1:0] (write-value) and edge-mode ext bits (write-1-to-clear).
REQ-019 Level ext bits SHALL follow the synchronised line; edge bits SHALL set on synchronised 0->1 and stay set until cleared by W1C.
REQ-020 SHALL increment count by 1 each COUNT_DIV cycles via a prescaler, wrapping 0xFFFFFFFF->0.
REQ-021 A count write SHALL load wr_data, suppress that cycle's increment and reset the prescaler to 0.
REQ-022 Timer bit i SHALL set (sticky) in the cycle after count==compare[i] and clear on any write to compare[i]; in a write cycle the clear wins.
REQ-023 int_req SHALL equal IE & ~EXL & |(ip & im), combinational from registered state.
REQ-024 int_ack with int_req high SHALL set EXL next cycle; int_ack with int_req low SHALL be ignored.
REQ-025 eret SHALL clear EXL next cycle; with simultaneous valid int_ack, EXL SHALL be 1.
REQ-026 A status write concurrent with valid int_ack SHALL take IE/IM from wr_data and force EXL=1.
REQ-027 A W1C of an edge bit concurrent with a new rising edge on that line SHALL leave the bit set.

Reset
REQ-028 On reset: count, compare[], prescaler, IE, EXL, IM, all ip bits and synchroniser flops SHALL be 0; int_req and int_pend SHALL read 0 in the cycle after reset is sampled.
REQ-029 Reset asserted mid-prescale or with pending edges SHALL discard all state with no residual request.

Configuration
REQ-030 With CP0_INTC_SYNC_EN defined, each ext_int line SHALL pass a two-flop synchroniser (ip visible 2 cycles after the line changes, level mode).
REQ-031 Without CP0_INTC_SYNC_EN, ext_int SHALL pass one register stage (ip visible 1 cycle after the line changes).

Verification
REQ-032 COUNT_DIV=2, write count=0xFFFFFFFE -> reads 0xFFFFFFFF two cycles later, 0x00000000 four cycles later.
REQ-033 compare[0]=5, count=3, IE=1, IM timer bit=1 -> timer ip and int_req rise one cycle after count reads 5; writing compare[0] clears int_req next cycle.
REQ-034 EDGE_MASK bit0=1, sync off, pulse ext_int[0] one cycle -> cause bit2 stays 1 until W1C of 0x4, int_req tracks it with IE=1, IM bit2=1.
REQ-035 int_req high, int_ack and eret together -> EXL=1, int_req 0 next cycle; eret alone later -> EXL=0, int_req returns 1.
REQ-036 Write cause=0x1 with IM bit0=1, IE=1 -> int_req 1 next cycle; reset mid-operation -> all reads 0, int_req 0.
REQ-037 CP0_INTC_SYNC_EN defined, level ext_int[1] rises -> cause bit3 set exactly 2 cycles later; undefined -> 1 cycle.

Source files
------------

// File: rtl/cp0_intc_if.sv
// Software register / pipeline handshake bus of the CP0 interrupt controller.
interface cp0_intc_if #(
  parameter int unsigned N_EXT   = 6,
  parameter int unsigned N_TIMER = 1
);
  localparam int unsigned P = 2 + N_EXT + N_TIMER;

  logic [N_EXT-1:0] ext_int;
  logic             wr_en;
  logic [3:0]       wr_sel;
  logic [31:0]      wr_data;
  logic [3:0]       rd_sel;
  logic [31:0]      rd_data;
  logic             int_ack;
  logic             eret;
  logic             int_req;
  logic [P-1:0]     int_pend;

  modport master (
    output ext_int, wr_en, wr_sel, wr_data, rd_sel, int_ack, eret,
    input  rd_data, int_req, int_pend
  );

  modport slave (
    input  ext_int, wr_en, wr_sel, wr_data, rd_sel, int_ack, eret,
    output rd_data, int_req, int_pend
  );
endinterface

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: count/compare timers, status/cause, ext line capture.
// Optional CP0_INTC_SYNC_EN: two-flop synchroniser on ext_int instead of one stage.
module cp0_intc #(
  parameter int unsigned       N_EXT     = 6,
  parameter int unsigned       N_TIMER   = 1,
  parameter int unsigned       COUNT_DIV = 2,
  parameter logic [N_EXT-1:0]  EDGE_MASK = '0
) (
  input  logic       clk,
  input  logic       reset,
  cp0_intc_if.slave  bus
);
  localparam int unsigned P  = 2 + N_EXT + N_TIMER;
  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [31:0]        r_count;
  logic [PW-1:0]      r_presc;
  logic [31:0]        r_cmp [N_TIMER];
  logic [N_TIMER-1:0] r_tip;
  logic               r_ie;
  logic               r_exl;
  logic [P-1:0]       r_im;
  logic [1:0]         r_soft;
  logic [N_EXT-1:0]   r_edge;
  logic [N_EXT-1:0]   r_ext_s1;
  logic [N_EXT-1:0]   r_ext_prev;

  logic [N_EXT-1:0]   w_ext_sync;
  logic [N_EXT-1:0]   w_rise;
  logic [N_EXT-1:0]   w_ext_ip;
  logic [N_EXT-1:0]   w_w1c;
  logic [P-1:0]       w_ip;
  logic [P-1:0]       w_pend;
  logic               w_req;
  logic               w_ack;
  logic               w_tick;
  logic               w_wr_count;
  logic               w_wr_status;
  logic               w_wr_cause;
  logic [N_TIMER-1:0] w_wr_cmp;
  logic [N_TIMER-1:0] w_match;

  // External line capture
  always_ff @(posedge clk) begin
    if (reset) r_ext_s1 <= '0;
    else       r_ext_s1 <= bus.ext_int;
  end

`ifdef CP0_INTC_SYNC_EN
  logic [N_EXT-1:0] r_ext_s2;

  always_ff @(posedge clk) begin
    if (reset) r_ext_s2 <= '0;
    else       r_ext_s2 <= r_ext_s1;
  end

  assign w_ext_sync = r_ext_s2;
`else
  assign w_ext_sync = r_ext_s1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_ext_prev <= '0;
    else       r_ext_prev <= w_ext_sync;
  end

  assign w_wr_count  = bus.wr_en && (bus.wr_sel == 4'd0);
  assign w_wr_status = bus.wr_en && (bus.wr_sel == 4'd1);
  assign w_wr_cause  = bus.wr_en && (bus.wr_sel == 4'd2);
  assign w_tick      = (r_presc == PRESC_MAX);

  always_comb begin
    w_wr_cmp = '0;
    w_match  = '0;
    for (int i = 0; i < int'(N_TIMER); i++) begin
      w_wr_cmp[i] = bus.wr_en && (bus.wr_sel == 4'(3 + i));
      w_match[i]  = (r_count == r_cmp[i]);
    end
  end

  // Edge bits stay latched until W1C; a rise in the same cycle wins over the clear
  assign w_w1c    = w_wr_cause ? bus.wr_data[2 +: N_EXT] : '0;
  assign w_rise   = w_ext_sync & ~r_ext_prev;
  assign w_ext_ip = (EDGE_MASK & r_edge) | (~EDGE_MASK & w_ext_sync);
  assign w_ip     = {r_tip, w_ext_ip, r_soft};
  assign w_pend   = w_ip & r_im;
  assign w_req    = r_ie & ~r_exl & (|w_pend);
  assign w_ack    = bus.int_ack & w_req;

  assign bus.int_req  = w_req;
  assign bus.int_pend = w_pend;

  // Count, prescaler and compare channels
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_presc <= '0;
      r_tip   <= '0;
      for (int i = 0; i < int'(N_TIMER); i++) r_cmp[i] <= '0;
    end else begin
      if (w_wr_count) begin
        r_count <= bus.wr_data;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      for (int i = 0; i < int'(N_TIMER); i++) begin
        if (w_wr_cmp[i]) begin
          r_cmp[i] <= bus.wr_data;
          r_tip[i] <= 1'b0;
        end else if (w_match[i]) begin
          r_tip[i] <= 1'b1;
        end
      end
    end
  end

  // Status and cause state; an accepted interrupt always lands with EXL set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie   <= 1'b0;
      r_exl  <= 1'b0;
      r_im   <= '0;
      r_soft <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr_status) begin
        r_ie <= bus.wr_data[0];
        r_im <= bus.wr_data[16 +: P];
      end
      if (w_ack)            r_exl <= 1'b1;
      else if (bus.eret)    r_exl <= 1'b0;
      else if (w_wr_status) r_exl <= bus.wr_data[1];
      if (w_wr_cause) r_soft <= bus.wr_data[1:0];
      r_edge <= ((r_edge & ~w_w1c) | w_rise) & EDGE_MASK;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_sel)
      4'd0: bus.rd_data = r_count;
      4'd1: begin
        bus.rd_data[0]        = r_ie;
        bus.rd_data[1]        = r_exl;
        bus.rd_data[16 +: P]  = r_im;
      end
      4'd2: bus.rd_data = 32'(w_ip);
      default: begin
        for (int i = 0; i < int'(N_TIMER); i++) begin
          if (bus.rd_sel == 4'(3 + i)) bus.rd_data = r_cmp[i];
        end
      end
    endcase
  end
endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed scenarios plus randomized run vs a reference model.
module tb_cp0_intc;
  localparam int unsigned N_EXT     = 6;
  localparam int unsigned N_TIMER   = 2;
  localparam int unsigned COUNT_DIV = 2;
  localparam int unsigned P         = 2 + N_EXT + N_TIMER;
  localparam logic [N_EXT-1:0] EDGE_MASK = 6'b000001;
  localparam int TBIT = 2 + N_EXT;
`ifdef CP0_INTC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  cp0_intc_if #(.N_EXT(N_EXT), .N_TIMER(N_TIMER)) bus ();

  cp0_intc #(.N_EXT(N_EXT), .N_TIMER(N_TIMER), .COUNT_DIV(COUNT_DIV), .EDGE_MASK(EDGE_MASK)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  // Reference model: architectural state plus a history of sampled ext lines
  logic [31:0]        m_count;
  int                 m_phase;
  logic [31:0]        m_cmp [N_TIMER];
  logic [N_TIMER-1:0] m_tip;
  logic               m_ie, m_exl;
  logic [P-1:0]       m_im;
  logic [1:0]         m_soft;
  logic [N_EXT-1:0]   m_edge;
  logic [N_EXT-1:0]   m_hist [4];

  function automatic logic [P-1:0] m_ip();
    logic [N_EXT-1:0] ext;
    ext = (EDGE_MASK & m_edge) | (~EDGE_MASK & m_hist[SYNC_LAT-1]);
    return {m_tip, ext, m_soft};
  endfunction

  function automatic logic m_req();
    return m_ie && !m_exl && ((m_ip() & m_im) != '0);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] sel);
    int s = int'(sel);
    if (s == 0) return m_count;
    if (s == 1) return 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 16);
    if (s == 2) return 32'(m_ip());
    if (s >= 3 && s < 3 + int'(N_TIMER)) return m_cmp[s-3];
    return 32'h0;
  endfunction

  function automatic void step_model();
    logic             ack, wr;
    logic [N_EXT-1:0] rise, w1c;
    int               sel;
    logic [31:0]      d;
    if (reset) begin
      m_count = '0; m_phase = 0; m_tip = '0; m_ie = 1'b0; m_exl = 1'b0;
      m_im = '0; m_soft = '0; m_edge = '0;
      for (int i = 0; i < int'(N_TIMER); i++) m_cmp[i] = '0;
      for (int k = 0; k < 4; k++) m_hist[k] = '0;
      return;
    end
    wr   = bus.wr_en;
    sel  = int'(bus.wr_sel);
    d    = bus.wr_data;
    ack  = bus.int_ack && m_req();
    rise = m_hist[SYNC_LAT-1] & ~m_hist[SYNC_LAT];
    for (int i = 0; i < int'(N_TIMER); i++) begin
      if (wr && sel == 3 + i) begin m_tip[i] = 1'b0; m_cmp[i] = d; end
      else if (m_count == m_cmp[i]) m_tip[i] = 1'b1;
    end
    if (wr && sel == 0) begin
      m_count = d; m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == int'(COUNT_DIV)) begin m_count = m_count + 1; m_phase = 0; end
    end
    if (ack) m_exl = 1'b1;
    else if (bus.eret) m_exl = 1'b0;
    else if (wr && sel == 1) m_exl = d[1];
    if (wr && sel == 1) begin m_ie = d[0]; m_im = d[16 +: P]; end
    w1c = '0;
    if (wr && sel == 2) begin m_soft = d[1:0]; w1c = d[2 +: N_EXT]; end
    m_edge = ((m_edge & ~w1c) | rise) & EDGE_MASK;
    for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = bus.ext_int;
  endfunction

  task automatic tick();
    @(posedge clk);
    step_model();
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] sel, output logic [31:0] v);
    bus.rd_sel = sel;
    #1;
    v = bus.rd_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    bus.ext_int = 6'($urandom);
    tick();
    n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", bus.int_req); end
    n_checks++; if (bus.int_pend !== '0) begin n_fail++; $display("FAIL reset_pend got=%h exp=0", bus.int_pend); end
    for (int s = 0; s < 7; s++) begin
      rd(4'(s), v);
      n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_rd sel=%0d got=%h exp=0", s, v); end
    end
    tick();
    bus.ext_int = '0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_count_wrap();
    logic [31:0] v;
    wr(4'd0, 32'hFFFF_FFFE);
    rd(4'd0, v);
    n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL count_load got=%h exp=fffffffe", v); end
    tick();
    rd(4'd0, v);
    n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL count_hold got=%h exp=fffffffe", v); end
    tick();
    rd(4'd0, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL count_plus2 got=%h exp=ffffffff", v); end
    repeat (2) tick();
    rd(4'd0, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL count_wrap got=%h exp=0", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    bit found = 0;
    wr(4'd1, 32'h1 | (32'h1 << (16 + TBIT)));
    wr(4'd3, 32'd5);
    wr(4'd0, 32'd3);
    for (int k = 0; k < 20 && !found; k++) begin
      rd(4'd0, v);
      if (v == 32'd5) begin
        found = 1;
        n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL timer_early got=%0b exp=0", bus.int_req); end
        tick();
        n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL timer_req got=%0b exp=1", bus.int_req); end
        rd(4'd2, v);
        n_checks++; if (v[TBIT] !== 1'b1) begin n_fail++; $display("FAIL timer_ip got=%0b exp=1", v[TBIT]); end
      end else begin
        tick();
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL timer_reach5 got=timeout exp=count5"); end
    wr(4'd3, 32'h100);
    n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL timer_clear got=%0b exp=0", bus.int_req); end
    rd(4'd2, v);
    n_checks++; if (v[TBIT] !== 1'b0) begin n_fail++; $display("FAIL timer_ip_clear got=%0b exp=0", v[TBIT]); end
    wr(4'd1, 32'h0);
  endtask

  task automatic test_edge();
    logic [31:0] v;
    wr(4'd1, 32'h1 | (32'h1 << 18));
    wr(4'd2, 32'h4);
    bus.ext_int[0] = 1'b1;
    tick();
    bus.ext_int[0] = 1'b0;
    repeat (SYNC_LAT) tick();
    for (int k = 0; k < 5; k++) begin
      rd(4'd2, v);
      n_checks++; if (v[2] !== 1'b1) begin n_fail++; $display("FAIL edge_hold k=%0d got=%0b exp=1", k, v[2]); end
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL edge_req k=%0d got=%0b exp=1", k, bus.int_req); end
      tick();
    end
    bus.ext_int[0] = 1'b1;
    repeat (SYNC_LAT) tick();
    wr(4'd2, 32'h4);
    rd(4'd2, v);
    n_checks++; if (v[2] !== 1'b1) begin n_fail++; $display("FAIL edge_w1c_race got=%0b exp=1", v[2]); end
    wr(4'd2, 32'h4);
    rd(4'd2, v);
    n_checks++; if (v[2] !== 1'b0) begin n_fail++; $display("FAIL edge_w1c got=%0b exp=0", v[2]); end
    n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL edge_req_clr got=%0b exp=0", bus.int_req); end
    bus.ext_int[0] = 1'b0;
    wr(4'd1, 32'h0);
  endtask

  task automatic test_ext_latency();
    logic [31:0] v;
    bus.ext_int = '0;
    repeat (3) tick();
    bus.ext_int[1] = 1'b1;
    tick();
    rd(4'd2, v);
    n_checks++; if (v[3] !== (SYNC_LAT == 1)) begin n_fail++; $display("FAIL lat_rise1 got=%0b exp=%0b", v[3], SYNC_LAT == 1); end
    tick();
    rd(4'd2, v);
    n_checks++; if (v[3] !== 1'b1) begin n_fail++; $display("FAIL lat_rise2 got=%0b exp=1", v[3]); end
    bus.ext_int[1] = 1'b0;
    tick();
    rd(4'd2, v);
    n_checks++; if (v[3] !== (SYNC_LAT != 1)) begin n_fail++; $display("FAIL lat_fall1 got=%0b exp=%0b", v[3], SYNC_LAT != 1); end
    tick();
    rd(4'd2, v);
    n_checks++; if (v[3] !== 1'b0) begin n_fail++; $display("FAIL lat_fall2 got=%0b exp=0", v[3]); end
  endtask

  task automatic test_ack_eret();
    logic [31:0] v;
    wr(4'd1, 32'h0001_0001);
    wr(4'd2, 32'h1);
    n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL soft_req got=%0b exp=1", bus.int_req); end
    bus.int_ack = 1'b1; bus.eret = 1'b1;
    tick();
    bus.int_ack = 1'b0; bus.eret = 1'b0;
    rd(4'd1, v);
    n_checks++; if (v !== 32'h0001_0003) begin n_fail++; $display("FAIL ack_eret_status got=%h exp=00010003", v); end
    n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL ack_eret_req got=%0b exp=0", bus.int_req); end
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    rd(4'd1, v);
    n_checks++; if (v !== 32'h0001_0001) begin n_fail++; $display("FAIL eret_status got=%h exp=00010001", v); end
    n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL eret_req got=%0b exp=1", bus.int_req); end
    bus.int_ack = 1'b1;
    wr(4'd1, 32'h0003_0001);
    bus.int_ack = 1'b0;
    rd(4'd1, v);
    n_checks++; if (v !== 32'h0003_0003) begin n_fail++; $display("FAIL ack_wr_status got=%h exp=00030003", v); end
    wr(4'd1, 32'h0001_0000);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    rd(4'd1, v);
    n_checks++; if (v !== 32'h0001_0000) begin n_fail++; $display("FAIL ack_ignored got=%h exp=00010000", v); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] v;
    wr(4'd1, 32'h0001_0005);
    wr(4'd2, 32'h1);
    bus.ext_int[0] = 1'b1;
    tick();
    n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req got=%0b exp=1", bus.int_req); end
    reset = 1'b1;
    tick();
    for (int s = 0; s < 5; s++) begin
      rd(4'(s), v);
      n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_rd sel=%0d got=%h exp=0", s, v); end
    end
    n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL midreset_req got=%0b exp=0", bus.int_req); end
    reset = 1'b0;
    bus.ext_int = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_req k=%0d got=%0b exp=0", k, bus.int_req); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  rs;
    logic [P-1:0] ep;
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 79) == 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_sel  = 4'($urandom_range(0, 6));
      bus.wr_data = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      for (int b = 0; b < int'(N_EXT); b++)
        if ($urandom_range(0, 3) == 0) bus.ext_int[b] = ~bus.ext_int[b];
      bus.int_ack = ($urandom_range(0, 3) == 0);
      bus.eret    = ($urandom_range(0, 7) == 0);
      rs          = 4'($urandom_range(0, 15));
      bus.rd_sel  = rs;
      #1;
      ep = m_ip() & m_im;
      n_checks++; if (bus.int_req !== m_req()) begin n_fail++; $display("FAIL rand_req c=%0d got=%0b exp=%0b", c, bus.int_req, m_req()); end
      n_checks++; if (bus.int_pend !== ep) begin n_fail++; $display("FAIL rand_pend c=%0d got=%h exp=%h", c, bus.int_pend, ep); end
      n_checks++; if (bus.rd_data !== m_read(rs)) begin n_fail++; $display("FAIL rand_rd c=%0d sel=%0d got=%h exp=%h", c, rs, bus.rd_data, m_read(rs)); end
      tick();
    end
    reset = 1'b0; bus.wr_en = 1'b0; bus.int_ack = 1'b0; bus.eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.ext_int = '0; bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
    bus.rd_sel = '0; bus.int_ack = 1'b0; bus.eret = 1'b0;
    test_reset();
    test_count_wrap();
    test_timer();
    test_edge();
    test_ext_latency();
    test_ack_eret();
    test_soft_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
